seq_div16x8: RTL and testbench

SEQ_DIV16X8 -- requirements
Module: seq_div16x8

---
 rtl/seq_div16x8.sv | 151 +++++++++++++++
 tb/tb_seq_div16x8.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div16x8.sv
// seq_div16x8 -- 16-by-8 unsigned sequential restoring divider.
// Produces one quotient bit per enabled clock, MSB first. Results are valid
// while done is high and then hold until the next accepted start.
// Optional build macro: SEQ_DIV_ZCHK_EN -- when defined, a zero divisor
// short-circuits the calculation and raises div_by_zero. When it is undefined,
// a zero divisor runs the normal 16 steps and div_by_zero is tied low.
module seq_div16x8 (
    input  logic        clk,
    input  logic        sclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Dividend bits leave from the MSB while quotient bits enter at the LSB,
    // so after 16 steps this register holds the complete quotient.
    logic [15:0] work;
    logic [7:0]  dvs;
    logic [8:0]  prem;
    logic [3:0]  step_cnt;

    logic [8:0]  prem_shift;
    logic [8:0]  prem_nxt;
    logic        q_bit;
    logic        run_step;
    logic        last_step;

`ifdef SEQ_DIV_ZCHK_EN
    logic        zero_pend;
`endif

    // The MSB of prem only becomes 1 when dividing by zero without the
    // zero check; it is shifted out on the next step and never read back.
    logic        unused_prem_msb;
    assign unused_prem_msb = prem[8];

    // One restoring step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        prem_shift = {prem[7:0], work[15]};
        q_bit      = (prem_shift >= {1'b0, dvs});
        prem_nxt   = q_bit ? (prem_shift - {1'b0, dvs}) : prem_shift;
    end

`ifdef SEQ_DIV_ZCHK_EN
    assign run_step  = !zero_pend;
    assign last_step = (step_cnt == 4'd15) || zero_pend;
`else
    assign run_step  = 1'b1;
    assign last_step = (step_cnt == 4'd15);
`endif

    // State register: synchronous clear wins over the clock enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values present before the edge.
        if (sclr) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, finish after the last step, one cycle in DONE.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath: operand capture, iterative step, and result registers.
    always_ff @(posedge clk) begin
        if (sclr) begin
            work      <= '0;
            dvs       <= '0;
            prem      <= '0;
            step_cnt  <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIV_ZCHK_EN
            zero_pend   <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work     <= dividend;
                        dvs      <= divisor;
                        prem     <= '0;
                        step_cnt <= '0;
`ifdef SEQ_DIV_ZCHK_EN
                        zero_pend <= (divisor == 8'd0);
`endif
                    end
                end
                CALC: begin
                    if (run_step) begin
                        work     <= {work[14:0], q_bit};
                        prem     <= prem_nxt;
                        step_cnt <= step_cnt + 4'd1;
                        if (step_cnt == 4'd15) begin
                            quotient  <= {work[14:0], q_bit};
                            remainder <= prem_nxt[7:0];
`ifdef SEQ_DIV_ZCHK_EN
                            div_by_zero <= 1'b0;
`endif
                        end
                    end
`ifdef SEQ_DIV_ZCHK_EN
                    if (zero_pend) begin
                        // The operand register still holds the untouched dividend.
                        quotient    <= 16'hFFFF;
                        remainder   <= work[7:0];
                        div_by_zero <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef SEQ_DIV_ZCHK_EN
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div16x8.sv
// tb_seq_div16x8 -- directed self-checking bench for seq_div16x8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_seq_div16x8;

    logic        clk = 1'b0;
    logic        sclr;
    logic        clk_en;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

`ifdef SEQ_DIV_ZCHK_EN
    localparam int   ZERO_LAT = 1;
    localparam logic ZERO_DBZ = 1'b1;
`else
    localparam int   ZERO_LAT = 16;
    localparam logic ZERO_DBZ = 1'b0;
`endif

    seq_div16x8 dut (
        .clk         (clk),
        .sclr        (sclr),
        .clk_en      (clk_en),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one division, measure edges to done, check results and hold.
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input int exp_lat, input logic [15:0] exp_q,
                           input logic [7:0] exp_r, input logic exp_z);
        int n;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy after accept"}, busy, 1);
        check({tag, " done after accept"}, done, 0);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div_by_zero"}, div_by_zero, exp_z);
        tick();
        check({tag, " done pulse width"}, done, 0);
        check({tag, " idle after done"}, busy, 0);
        check({tag, " quotient hold"}, quotient, exp_q);
        check({tag, " remainder hold"}, remainder, exp_r);
        check({tag, " div_by_zero hold"}, div_by_zero, exp_z);
    endtask

    initial begin
        int n;
        int saw_done;

        sclr     = 1'b1;
        clk_en   = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        sclr = 1'b0;
        tick();

        // Basic arithmetic: 1000/7 = 142 r6; 65535/255 = 257 r0; 100/200 = 0 r100.
        run_div("d1000_7", 16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0);
        run_div("d65535_255", 16'd65535, 8'd255, 16, 16'd257, 8'd0, 1'b0);
        run_div("d100_200", 16'd100, 8'd200, 16, 16'd0, 8'd100, 1'b0);
        run_div("d65535_1", 16'hFFFF, 8'd1, 16, 16'hFFFF, 8'd0, 1'b0);
        run_div("d255_16", 16'd255, 8'd16, 16, 16'd15, 8'd15, 1'b0);

        // Clock-enable stall of 5 cycles after step 8: done 21 clocks after accept.
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        repeat (8) begin
            tick();
            n++;
        end
        clk_en = 1'b0;
        repeat (5) begin
            tick();
            n++;
        end
        check("stall busy", busy, 1);
        check("stall done", done, 0);
        clk_en = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("stall latency", n, 21);
        check("stall quotient", quotient, 16'd142);
        check("stall remainder", remainder, 8'd6);
        tick();

        // start re-pulsed mid-calculation with other operands is ignored.
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        repeat (3) begin
            tick();
            n++;
        end
        dividend = 16'd500;
        divisor  = 8'd3;
        start    = 1'b1;
        tick();
        n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("repulse latency", n, 16);
        check("repulse quotient", quotient, 16'd142);
        check("repulse remainder", remainder, 8'd6);
        tick();
        check("repulse idle", busy, 0);
        tick();
        check("repulse not queued", busy, 0);

        // sclr at step 10 aborts with no done pulse and clears outputs.
        dividend = 16'd65535;
        divisor  = 8'd255;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort div_by_zero", div_by_zero, 0);
        saw_done = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        check("abort no done pulse", saw_done, 0);
        run_div("fresh_after_abort", 16'd100, 8'd200, 16, 16'd0, 8'd100, 1'b0);

        // start on the same edge as sclr is discarded.
        dividend = 16'd1000;
        divisor  = 8'd7;
        sclr     = 1'b1;
        start    = 1'b1;
        tick();
        sclr  = 1'b0;
        start = 1'b0;
        check("sclr+start busy", busy, 0);
        tick();
        check("sclr+start stays idle", busy, 0);

        // Division by zero.
        run_div("div_zero", 16'h1234, 8'd0, ZERO_LAT, 16'hFFFF, 8'h34, ZERO_DBZ);
        run_div("after_zero", 16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
